// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage execution unit. Decodes ALUOp/funct into an ALU
// control code, produces a registered single-cycle result, and runs an
// iterative unsigned shift-add multiplier that writes the HI/LO pair.
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [3:0]       operation,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             illegal
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MULTU = 4'b1000;
   localparam logic [3:0] OP_MFHI  = 4'b1001;
   localparam logic [3:0] OP_MFLO  = 4'b1010;
   localparam logic [3:0] OP_ILL   = 4'b1111;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

   state_t           state_q,     state_d;
   logic [3:0]       operation_q, operation_d;
   logic [WIDTH-1:0] result_q,    result_d;
   logic             zero_q,      zero_d;
   logic [WIDTH-1:0] hi_q,        hi_d;
   logic [WIDTH-1:0] lo_q,        lo_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;
   logic             illegal_q,   illegal_d;
   logic [WIDTH-1:0] mcand_q,     mcand_d;
   logic [WIDTH-1:0] prod_hi_q,   prod_hi_d;
   logic [WIDTH-1:0] prod_lo_q,   prod_lo_d;
   logic [CW-1:0]    cnt_q,       cnt_d;

   logic [3:0]       dec_op_s;
   logic             dec_ill_s;
   logic             slt_s;
   logic [WIDTH-1:0] alu_res_s;
   logic [WIDTH:0]   mul_sum_s;
   logic [WIDTH-1:0] step_hi_s;
   logic [WIDTH-1:0] step_lo_s;

   // Decode ALUOp/funct into the ALU control code and flag unknown encodings.
   always_comb begin
      dec_op_s  = OP_ADD;
      dec_ill_s = 1'b0;
      case (alu_op)
         2'b00: dec_op_s = OP_ADD;
         2'b01: dec_op_s = OP_SUB;
         2'b10: begin
            case (funct)
               6'b100000: dec_op_s = OP_ADD;
               6'b100010: dec_op_s = OP_SUB;
               6'b100100: dec_op_s = OP_AND;
               6'b100101: dec_op_s = OP_OR;
               6'b101010: dec_op_s = OP_SLT;
               6'b011001: dec_op_s = OP_MULTU;
               6'b010000: dec_op_s = OP_MFHI;
               6'b010010: dec_op_s = OP_MFLO;
               default: begin
                  dec_op_s  = OP_ILL;
                  dec_ill_s = 1'b1;
               end
            endcase
         end
         default: begin
            dec_op_s  = OP_ILL;
            dec_ill_s = 1'b1;
         end
      endcase
   end

   // Single-cycle ALU result for the decoded operation.
   always_comb begin
      slt_s     = ($signed(a) < $signed(b));
      alu_res_s = {WIDTH{1'b0}};
      case (dec_op_s)
         OP_ADD:  alu_res_s = a + b;
         OP_SUB:  alu_res_s = a - b;
         OP_AND:  alu_res_s = a & b;
         OP_OR:   alu_res_s = a | b;
         OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, slt_s};
         OP_MFHI: alu_res_s = hi_q;
         OP_MFLO: alu_res_s = lo_q;
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
   end

   // One shift-add step: add the multiplicand into the upper half when the
   // current multiplier LSB is set, then shift the 2*WIDTH product right.
   always_comb begin
      if (prod_lo_q[0]) begin
         mul_sum_s = {1'b0, prod_hi_q} + {1'b0, mcand_q};
      end else begin
         mul_sum_s = {1'b0, prod_hi_q};
      end
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], prod_lo_q[WIDTH-1:1]};
   end

   // Next-state logic for the IDLE/MUL controller and all registered outputs.
   always_comb begin
      state_d     = state_q;
      operation_d = operation_q;
      result_d    = result_q;
      zero_d      = zero_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      illegal_d   = 1'b0;
      mcand_d     = mcand_q;
      prod_hi_d   = prod_hi_q;
      prod_lo_d   = prod_lo_q;
      cnt_d       = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (dec_op_s == OP_MULTU) begin
                  state_d     = ST_MUL;
                  busy_d      = 1'b1;
                  operation_d = OP_MULTU;
                  mcand_d     = a;
                  prod_hi_d   = {WIDTH{1'b0}};
                  prod_lo_d   = b;
                  cnt_d       = {CW{1'b0}};
               end else if (dec_ill_s) begin
                  operation_d = OP_ILL;
                  result_d    = {WIDTH{1'b0}};
                  zero_d      = 1'b1;
                  done_d      = 1'b1;
                  illegal_d   = 1'b1;
               end else begin
                  operation_d = dec_op_s;
                  result_d    = alu_res_s;
                  zero_d      = (alu_res_s == {WIDTH{1'b0}});
                  done_d      = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            prod_hi_d = step_hi_s;
            prod_lo_d = step_lo_s;
            if (cnt_q == CW'(WIDTH - 1)) begin
               hi_d     = step_hi_s;
               lo_d     = step_lo_s;
               result_d = step_lo_s;
               zero_d   = (step_lo_s == {WIDTH{1'b0}});
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         operation_q <= OP_ADD;
         result_q    <= {WIDTH{1'b0}};
         zero_q      <= 1'b1;
         hi_q        <= {WIDTH{1'b0}};
         lo_q        <= {WIDTH{1'b0}};
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         illegal_q   <= 1'b0;
         mcand_q     <= {WIDTH{1'b0}};
         prod_hi_q   <= {WIDTH{1'b0}};
         prod_lo_q   <= {WIDTH{1'b0}};
         cnt_q       <= {CW{1'b0}};
      end else begin
         state_q     <= state_d;
         operation_q <= operation_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         illegal_q   <= illegal_d;
         mcand_q     <= mcand_d;
         prod_hi_q   <= prod_hi_d;
         prod_lo_q   <= prod_lo_d;
         cnt_q       <= cnt_d;
      end
   end

   assign operation = operation_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign illegal   = illegal_q;

endmodule
